// File: rtl/ste_pulse_gen.sv
// ste_pulse_gen: stretches single-cycle event pulses into level pulses of a
// programmable high-time, followed by an enforced minimum low gap. Triggers
// that arrive while a pulse or its gap is in progress are queued in a
// saturating counter (or, with RETRIG=1, extend the active pulse instead).
// Every output comes straight from a flop.

module ste_pulse_gen #(
    parameter int   CNT_W    = 16,
    parameter int   PEND_W   = 4,
    parameter bit   RETRIG   = 1'b0,
    parameter logic IDLE_LVL = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trig_i,
    input  logic [CNT_W-1:0]  width_i,
    input  logic [CNT_W-1:0]  gap_i,
    input  logic              clr_i,
    output logic              pulse_o,
    output logic              busy_o,
    output logic [PEND_W-1:0] pend_o,
    output logic              ovf_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } state_t;

    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  w_q, w_d;
    logic [CNT_W-1:0]  g_q, g_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              ovf_q, ovf_d;
    logic              pulse_d, busy_d;

    logic [CNT_W-1:0]  gap_eff;
    logic              width_ok;
    logic              cnt_last;
    logic              q_inc, q_dec;

    // A zero gap still has to give one low cycle so back-to-back pulses
    // remain distinguishable; a zero width means "no pulse".
    assign gap_eff  = (gap_i == '0) ? CNT_ONE : gap_i;
    assign width_ok = (width_i != '0);
    assign cnt_last = (cnt_q <= CNT_ONE);

    // Next-state, counter, latched-width and queue logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_d     = w_q;
        g_d     = g_q;
        pend_d  = pend_q;
        ovf_d   = ovf_q;
        q_inc   = 1'b0;
        q_dec   = 1'b0;

        case (state_q)
            IDLE: begin
                if (trig_i && width_ok) begin
                    state_d = ACTIVE;
                    w_d     = width_i;
                    g_d     = gap_eff;
                    cnt_d   = width_i;
                end else if (!trig_i && (pend_q != '0) && width_ok) begin
                    // Triggers left queued while width_i was zero are served
                    // as soon as a usable width shows up.
                    state_d = ACTIVE;
                    w_d     = width_i;
                    g_d     = gap_eff;
                    cnt_d   = width_i;
                    q_dec   = 1'b1;
                end
            end

            ACTIVE: begin
                if (trig_i && RETRIG) begin
                    cnt_d = w_q;
                end else begin
                    if (trig_i) begin
                        q_inc = 1'b1;
                    end
                    if (cnt_last) begin
                        state_d = GAP;
                        cnt_d   = g_q;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end

            GAP: begin
                if (trig_i) begin
                    q_inc = 1'b1;
                end
                if (cnt_last) begin
                    if ((pend_q != '0) && width_ok) begin
                        state_d = ACTIVE;
                        w_d     = width_i;
                        g_d     = gap_eff;
                        cnt_d   = width_i;
                        q_dec   = 1'b1;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // A simultaneous enqueue and dequeue leaves the count alone, so the
        // new trigger is kept even when the queue is full.
        if (q_inc && !q_dec) begin
            if (pend_q == PEND_MAX) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + PEND_W'(1);
            end
        end else if (q_dec && !q_inc) begin
            pend_d = pend_q - PEND_W'(1);
        end

        pulse_d = (state_d == ACTIVE) ? ~IDLE_LVL : IDLE_LVL;
        busy_d  = (state_d != IDLE);
    end

    // State, counters and registered outputs; reset wins over soft clear.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            w_q     <= '0;
            g_q     <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            pulse_o <= IDLE_LVL;
            busy_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
            g_q     <= g_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            pulse_o <= pulse_d;
            busy_o  <= busy_d;
        end
    end

    assign pend_o = pend_q;
    assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_ste_pulse_gen.sv
// tb_ste_pulse_gen: directed bench for ste_pulse_gen. Three instances cover
// the default queueing build, a retrigger build with inverted idle level and
// a shallow-queue build for overflow. Expected waveforms are hand-written
// cycle windows relative to the cycle after a reset.

module tb_ste_pulse_gen;

    logic        clk;
    logic        rst;
    logic        trig  [3];
    logic        clr   [3];
    logic [15:0] width [3];
    logic [15:0] gap   [3];
    logic        pulse [3];
    logic        busy  [3];
    logic        ovf   [3];
    logic [3:0]  pend0;
    logic [3:0]  pend1;
    logic [1:0]  pend2;

    int checks = 0;
    int errors = 0;
    int pulses;
    logic prevPulse;

    ste_pulse_gen #(.CNT_W(16), .PEND_W(4), .RETRIG(1'b0), .IDLE_LVL(1'b0)) dut0 (
        .clk(clk), .rst(rst), .trig_i(trig[0]), .width_i(width[0]), .gap_i(gap[0]),
        .clr_i(clr[0]), .pulse_o(pulse[0]), .busy_o(busy[0]), .pend_o(pend0), .ovf_o(ovf[0])
    );

    ste_pulse_gen #(.CNT_W(16), .PEND_W(4), .RETRIG(1'b1), .IDLE_LVL(1'b1)) dut1 (
        .clk(clk), .rst(rst), .trig_i(trig[1]), .width_i(width[1]), .gap_i(gap[1]),
        .clr_i(clr[1]), .pulse_o(pulse[1]), .busy_o(busy[1]), .pend_o(pend1), .ovf_o(ovf[1])
    );

    ste_pulse_gen #(.CNT_W(16), .PEND_W(2), .RETRIG(1'b0), .IDLE_LVL(1'b0)) dut2 (
        .clk(clk), .rst(rst), .trig_i(trig[2]), .width_i(width[2]), .gap_i(gap[2]),
        .clr_i(clr[2]), .pulse_o(pulse[2]), .busy_o(busy[2]), .pend_o(pend2), .ovf_o(ovf[2])
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit inR(input int t, input int lo, input int hi);
        return (t >= lo) && (t <= hi);
    endfunction

    function automatic int pendOf(input int d);
        case (d)
            0:       return int'(pend0);
            1:       return int'(pend1);
            default: return int'(pend2);
        endcase
    endfunction

    task automatic checkOutput(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input int d, input string name, input int t,
                            input bit expActive, input bit expBusy,
                            input int expPend, input bit expOvf);
        bit lvl;
        lvl = (d == 1);
        checkOutput($sformatf("%s_pulse@%0d", name, t), int'(pulse[d]), int'(expActive ^ lvl));
        checkOutput($sformatf("%s_busy@%0d", name, t), int'(busy[d]), int'(expBusy));
        checkOutput($sformatf("%s_pend@%0d", name, t), pendOf(d), expPend);
        checkOutput($sformatf("%s_ovf@%0d", name, t), int'(ovf[d]), int'(expOvf));
    endtask

    task automatic applyStimulus(input int d, input logic tr, input logic cl);
        trig[d] = tr;
        clr[d]  = cl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        for (int d = 0; d < 3; d++) begin
            applyStimulus(d, 1'b0, 1'b0);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            trig[d]  = 1'b0;
            clr[d]   = 1'b0;
            width[d] = 16'd0;
            gap[d]   = 16'd0;
        end
        tick();

        // Single pulse; width/gap changed mid-pulse must not matter.
        $display("[TB] single pulse");
        doReset();
        width[0] = 16'd5; gap[0] = 16'd3;
        for (int t = 0; t <= 22; t++) begin
            checkAll(0, "single", t, inR(t, 11, 15), inR(t, 11, 18), 0, 1'b0);
            if (t == 12) begin
                width[0] = 16'd9; gap[0] = 16'd7;
            end
            applyStimulus(0, t == 10, 1'b0);
            tick();
        end

        // Two triggers queued behind a running pulse.
        $display("[TB] queueing");
        doReset();
        width[0] = 16'd4; gap[0] = 16'd2;
        for (int t = 0; t <= 32; t++) begin
            checkAll(0, "queue", t,
                     inR(t, 11, 14) || inR(t, 17, 20) || inR(t, 23, 26),
                     inR(t, 11, 28),
                     (t == 13) ? 1 : inR(t, 14, 16) ? 2 : inR(t, 17, 22) ? 1 : 0,
                     1'b0);
            applyStimulus(0, (t == 10) || (t == 12) || (t == 13), 1'b0);
            tick();
        end

        // Retrigger extends the pulse without a low glitch (inverted level).
        $display("[TB] retrigger");
        doReset();
        width[1] = 16'd6; gap[1] = 16'd2;
        for (int t = 0; t <= 26; t++) begin
            checkAll(1, "retrig", t, inR(t, 11, 20), inR(t, 11, 22), 0, 1'b0);
            applyStimulus(1, (t == 10) || (t == 14), 1'b0);
            tick();
        end

        // Queue overflow on a 2-bit queue, then soft clear.
        $display("[TB] overflow");
        doReset();
        width[2] = 16'd20; gap[2] = 16'd1;
        for (int t = 0; t <= 34; t++) begin
            checkAll(2, "ovf", t, inR(t, 11, 30), inR(t, 11, 30),
                     (t == 12) ? 1 : (t == 13) ? 2 : inR(t, 14, 30) ? 3 : 0,
                     inR(t, 15, 30));
            applyStimulus(2, inR(t, 10, 14), t == 30);
            tick();
        end

        // Zero gap gives exactly one low cycle between queued pulses.
        $display("[TB] zero gap");
        doReset();
        width[0] = 16'd3; gap[0] = 16'd0;
        for (int t = 0; t <= 26; t++) begin
            checkAll(0, "gap0", t,
                     inR(t, 11, 13) || inR(t, 15, 17) || inR(t, 19, 21),
                     inR(t, 11, 22),
                     (t == 12) ? 1 : inR(t, 13, 14) ? 2 : inR(t, 15, 18) ? 1 : 0,
                     1'b0);
            applyStimulus(0, inR(t, 10, 12), 1'b0);
            tick();
        end

        // Zero-width trigger in IDLE is discarded.
        $display("[TB] zero width");
        doReset();
        width[0] = 16'd0; gap[0] = 16'd3;
        for (int t = 0; t <= 10; t++) begin
            checkAll(0, "w0", t, 1'b0, 1'b0, 0, 1'b0);
            applyStimulus(0, t == 5, 1'b0);
            tick();
        end

        // Reset during ACTIVE drops the pulse and the queue.
        $display("[TB] reset mid-pulse");
        doReset();
        width[0] = 16'd10; gap[0] = 16'd2;
        for (int t = 0; t <= 20; t++) begin
            checkAll(0, "rstmid", t, inR(t, 4, 8), inR(t, 4, 8),
                     inR(t, 6, 8) ? 1 : 0, 1'b0);
            applyStimulus(0, (t == 3) || (t == 5), 1'b0);
            rst = (t == 8);
            tick();
        end
        rst = 1'b0;

        // Trigger coinciding with the end-of-gap dequeue is kept.
        $display("[TB] simultaneous dequeue");
        doReset();
        width[0] = 16'd2; gap[0] = 16'd2;
        pulses = 0;
        prevPulse = 1'b0;
        for (int t = 0; t <= 26; t++) begin
            checkAll(0, "simul", t,
                     inR(t, 11, 12) || inR(t, 15, 16) || inR(t, 19, 20),
                     inR(t, 11, 22),
                     inR(t, 12, 18) ? 1 : 0,
                     1'b0);
            if (pulse[0] && !prevPulse) begin
                pulses++;
            end
            prevPulse = pulse[0];
            applyStimulus(0, (t == 10) || (t == 11) || (t == 14), 1'b0);
            tick();
        end
        checkOutput("simul_pulse_count", pulses, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ste_pulse_gen.md
Name: ste_pulse_gen

Overview:
Converts single-cycle event pulses, such as edge-detector outputs, back into level pulses of programmable width. Supports an enforced minimum low gap between pulses, queuing of triggers that arrive while busy, and optional retrigger. Drives LEDs, external strobes and display blanking in the multimeter, at the output end of the event path.

Parameters:
CNT_W, 16, width of the high-time and gap counters and of width_i/gap_i.
PEND_W, 4, width of the pending-trigger counter; maximum queue depth is 2^PEND_W-1.
RETRIG, 0, 1 = a trigger during the ACTIVE phase reloads the high-time counter (the pulse is extended and nothing is queued); 0 = the trigger is queued.
IDLE_LVL, 0, level of pulse_o when no pulse is active; the active level is ~IDLE_LVL.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
trig_i  input  1  event request; every high cycle counts as one trigger
width_i  input  CNT_W  pulse high-time in clk cycles; sampled at pulse start
gap_i  input  CNT_W  minimum low-time after a pulse; sampled at pulse start; 0 is treated as 1
clr_i  input  1  synchronous soft clear
pulse_o  output  1  generated pulse, registered
busy_o  output  1  high while state is not IDLE, registered
pend_o  output  PEND_W  number of queued triggers
ovf_o  output  1  sticky flag: a trigger was lost because the queue was full

Behaviour:
- Interface: one clock; reset is synchronous and active-high. rst has priority over everything, and clr_i is next.
- Reset/clear values: state=IDLE, pulse_o=IDLE_LVL, busy_o=0, pend_o=0, ovf_o=0. Counters and latched widths are cleared.
- Trigger sampled in the same cycle as clr_i: ignored.
- All outputs are flop outputs. There is no combinational path from input to output.

State machine (IDLE, ACTIVE, GAP):
- IDLE:
  - trig_i=1 and width_i!=0 -> ACTIVE. Latch W=width_i and G=max(gap_i,1).
  - trig_i=1 and width_i=0 -> trigger is discarded. State stays IDLE, pend_o is unchanged, no pulse.
- ACTIVE:
  - pulse_o=~IDLE_LVL for exactly W cycles, then -> GAP.
- GAP:
  - pulse_o=IDLE_LVL for exactly G cycles.
  - At the end of GAP, if pend_o>0 and width_i!=0: decrement pend_o, latch new W/G, -> ACTIVE.
  - Otherwise -> IDLE. Any pending triggers remain queued while width_i=0.

Timing:
- Latency: trig_i high in cycle t (IDLE) -> pulse_o active in cycles t+1 .. t+W, inactive t+W+1 .. t+W+G.
- A queued pulse starts at cycle t+W+G+1. busy_o follows the same timing (high t+1 .. t+W+G).
- A trigger arriving in the cycle after GAP ends with nothing pending sees IDLE and starts normally.

Trigger handling while busy:
- A trigger in ACTIVE with RETRIG=0, or any trigger in GAP: pend_o+1.
- A trigger in ACTIVE with RETRIG=1: the high-time counter restarts with the latched W. The pulse stays active W cycles after that trigger, with no low glitch. pend_o is unchanged.

Queue boundaries:
- Queue full: a trigger when pend_o = 2^PEND_W-1 is dropped and sets ovf_o=1. ovf_o clears only on rst or clr_i.
- A trigger in the same cycle as the end-of-GAP dequeue: pend_o is unchanged (+1-1), and the trigger is counted, not lost.
- width_i/gap_i changes mid-pulse have no effect until the next pulse start.

Counters and arithmetic:
- Counters are unsigned CNT_W-bit, counting down with no wrap.
- Maximum high-time is 2^CNT_W-1 cycles.

Test Plan:
- Single pulse: width_i=5, gap_i=3, one trig at t=10 -> pulse_o=1 for t=11..15, 0 at t=16; busy_o=1 for t=11..18; pend_o stays 0.
- Queueing (RETRIG=0): width_i=4, gap_i=2, triggers at t=10, 12, 13 -> pend_o reaches 2; pulses active t=11..14, 17..20, 23..26; busy_o=0 at t=29.
- Retrigger (RETRIG=1): width_i=6, triggers at t=10 and t=14 -> pulse_o continuously 1 for t=11..20, then gap; pend_o=0.
- Overflow (PEND_W=2): width_i=20, triggers at t=10..14 -> pend_o saturates at 3, ovf_o=1 from t=15; a clr_i at t=30 -> pend_o=0, ovf_o=0, pulse_o=IDLE_LVL at t=31.
- Corner cases: gap_i=0 with 2 queued triggers -> exactly 1 low cycle between pulses; width_i=0 trigger in IDLE -> no pulse, pend_o=0; rst asserted mid-ACTIVE -> next cycle all outputs at reset values.
- Simultaneity: a trigger in the cycle of the end-of-GAP dequeue -> pend_o unchanged; that extra pulse is emitted later (total pulse count equals trigger count).
